// File: rtl/bitserial_fifo_pkg.sv
// bitserial_fifo_pkg: shared defaults and serializer state type
// for the bit-serial transpose FIFO.
package bitserial_fifo_pkg;

  localparam int BSF_LANES_DEF = 64;
  localparam int BSF_WIDTH_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bsf_state_e;

endpackage

// File: rtl/bsf_lane_shreg.sv
// bsf_lane_shreg: one lane's parallel-in/serial-out register.
// Ports: clk, reset, load (take d), shift (MSB out, 0 in), d, q (serial MSB).
module bsf_lane_shreg
  import bitserial_fifo_pkg::*;
#(
  parameter int WIDTH = BSF_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q
);

  logic [WIDTH-1:0] r;

  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '0;
    end else if (load) begin
      r <= d;
    end else if (shift) begin
      r <= {r[WIDTH-2:0], 1'b0};
    end
  end

  assign q = r[WIDTH-1];

endmodule

// File: rtl/bitserial_fifo.sv
// bitserial_fifo: LANES-word bank transposed into WIDTH-cycle bit-serial
// frames. Ports: clk, reset, in_valid/in_data/in_ready, out_valid/out_ready,
// out_bits, out_first, out_last; flush exists with BITSERIAL_FIFO_FLUSH_EN.
module bitserial_fifo
  import bitserial_fifo_pkg::*;
#(
  parameter int LANES = BSF_LANES_DEF,
  parameter int WIDTH = BSF_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
`ifdef BITSERIAL_FIFO_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_bits,
  output logic             out_first,
  output logic             out_last
);

  localparam int CW = $clog2(LANES + 1);
  localparam int BW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bcnt;
  bsf_state_e       state;
  logic [WIDTH-1:0] bank [LANES];

  logic busy;
  logic full;
  logic full_eff;
  logic push;
  logic fire;
  logic last;
  logic xfer;

  assign busy = (state == BUSY);
  assign full = (cnt == CW'(LANES));
  assign push = in_valid & in_ready;
  assign fire = busy & out_ready;
  assign last = busy && (bcnt == BW'(WIDTH - 1));

`ifdef BITSERIAL_FIFO_FLUSH_EN
  logic pend;
  logic flush_now;

  // A flush that arrives with a push waits one cycle so the
  // pushed word lands in the bank before the hand-off.
  assign flush_now = flush && (cnt != '0) && !push;
  assign full_eff  = full | pend | flush_now;
  assign in_ready  = !full && !pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (xfer) begin
      pend <= 1'b0;
    end else if (flush && (push || cnt != '0)) begin
      pend <= 1'b1;
    end
  end
`else
  assign full_eff = full;
  assign in_ready = !full;
`endif

  // Reload either from idle or exactly as the last slice is consumed,
  // so back-to-back frames leave no gap.
  assign xfer = full_eff && (!busy || (fire && last));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      for (int k = 0; k < LANES; k++) begin
        bank[k] <= '0;
      end
    end else if (xfer) begin
      cnt <= '0;
      for (int k = 0; k < LANES; k++) begin
        bank[k] <= '0;
      end
    end else if (push) begin
      cnt     <= cnt + CW'(1);
      bank[0] <= in_data;
      for (int k = 1; k < LANES; k++) begin
        bank[k] <= bank[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bcnt  <= '0;
    end else if (xfer) begin
      state <= BUSY;
      bcnt  <= '0;
    end else if (fire) begin
      if (last) begin
        state <= IDLE;
        bcnt  <= '0;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic q;

    bsf_lane_shreg #(
      .WIDTH(WIDTH)
    ) u_shreg (
      .clk  (clk),
      .reset(reset),
      .load (xfer),
      .shift(fire & ~xfer),
      .d    (bank[k]),
      .q    (q)
    );

    assign out_bits[k] = busy & q;
  end

  assign out_valid = busy;
  assign out_first = busy && (bcnt == '0);
  assign out_last  = last;

endmodule

// File: tb/tb_bitserial_fifo.sv
// tb_bitserial_fifo: directed checks of bitserial_fifo at LANES=4, WIDTH=4.
// Define BITSERIAL_FIFO_FLUSH_EN to also exercise flush.
module tb_bitserial_fifo;

  localparam int L = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [L-1:0] out_bits;
  logic         out_first;
  logic         out_last;
`ifdef BITSERIAL_FIFO_FLUSH_EN
  logic         flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [L-1:0] obs [$];
  logic [L-1:0] exp3 [8];
  logic [W-1:0] wrd [8];
  int lowcnt;
  int guard;

  bitserial_fifo #(
    .LANES(L),
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef BITSERIAL_FIFO_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bits (out_bits),
    .out_first(out_first),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic rec();
    if (out_valid) obs.push_back(out_bits);
  endtask

  task automatic push4(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data = a; tick();
    in_data = b; tick();
    in_data = c; tick();
    in_data = d; tick();
    in_valid = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [L-1:0] s0,
                       input logic [L-1:0] s1, input logic [L-1:0] s2,
                       input logic [L-1:0] s3);
    logic [L-1:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_bits"}, out_bits, s[i]);
      chk({tag, "_first"}, out_first, i == 0);
      chk({tag, "_last"}, out_last, i == 3);
      tick();
    end
    chk({tag, "_done"}, out_valid, 1'b0);
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bits", out_bits, 4'b0000);
    chk("rst_first", out_first, 1'b0);
    chk("rst_last", out_last, 1'b0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", in_ready, 1'b1);

    // fill and serialize: lane3=A lane2=5 lane1=F lane0=0
    push4(4'hA, 4'h5, 4'hF, 4'h0);
    chk("fill_ready_low", in_ready, 1'b0);
    chk("fill_not_valid", out_valid, 1'b0);
    tick();
    frame("f1", 4'b1010, 4'b0110, 4'b1010, 4'b0110);

    // back-pressure: lane3=C lane2=3 lane1=6 lane0=9
    push4(4'hC, 4'h3, 4'h6, 4'h9);
    chk("bp_ready_low", in_ready, 1'b0);
    tick();
    chk("bp_s0", out_bits, 4'b1001);
    chk("bp_s0_first", out_first, 1'b1);
    tick();
    chk("bp_s1", out_bits, 4'b1010);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'h1; tick();
    chk("bp_hold1", out_bits, 4'b1010);
    chk("bp_hold1_first", out_first, 1'b0);
    in_data = 4'h2; tick();
    chk("bp_hold2", out_bits, 4'b1010);
    in_data = 4'h3; tick();
    chk("bp_hold3", out_bits, 4'b1010);
    chk("bp_hold3_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    in_data = 4'h4; tick();
    chk("bp_s2", out_bits, 4'b0110);
    chk("bp_5th_stall", in_ready, 1'b0);
    in_data = 4'h5; tick();
    chk("bp_s3", out_bits, 4'b0101);
    chk("bp_s3_last", out_last, 1'b1);
    chk("bp_5th_stall2", in_ready, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("bp_handoff_ready", in_ready, 1'b1);
    frame("f2", 4'b0000, 4'b0001, 4'b0110, 4'b1010);

    // overlapped streaming of 8 words
    wrd = '{4'h8, 4'h4, 4'h2, 4'h1, 4'hF, 4'hE, 4'hD, 4'hC};
    exp3 = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
             4'b1111, 4'b1111, 4'b1100, 4'b1010};
    obs.delete();
    lowcnt = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = wrd[i];
      guard = 0;
      while (!in_ready && guard < 10) begin
        lowcnt++;
        guard++;
        tick();
        rec();
      end
      tick();
      rec();
    end
    in_valid = 1'b0;
    guard = 0;
    while (obs.size() < 8 && guard < 40) begin
      guard++;
      tick();
      rec();
    end
    chk("ov_ready_low_cycles", lowcnt, 1);
    chk("ov_slice_count", obs.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ov_slice%0d", i),
          (i < obs.size()) ? obs[i] : 4'bxxxx, exp3[i]);
    end
    tick();
    chk("ov_idle", out_valid, 1'b0);

    // reset mid-frame with a partial bank
    push4(4'hA, 4'h5, 4'hF, 4'h0);
    tick();
    chk("rm_s0", out_bits, 4'b1010);
    tick();
    chk("rm_s1", out_bits, 4'b0110);
    in_valid = 1'b1;
    in_data = 4'h7;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rm_valid", out_valid, 1'b0);
    chk("rm_bits", out_bits, 4'b0000);
    chk("rm_ready", in_ready, 1'b1);
    chk("rm_first", out_first, 1'b0);
    chk("rm_last", out_last, 1'b0);
    reset = 1'b0;
    tick();
    chk("rm_quiet", out_valid, 1'b0);
    push4(4'h8, 4'h4, 4'h2, 4'h1);
    chk("rm_refill_wait", out_valid, 1'b0);
    tick();
    frame("f3", 4'b1000, 4'b0100, 4'b0010, 4'b0001);

`ifdef BITSERIAL_FIFO_FLUSH_EN
    // flush a 2-word bank: lane1=3 lane0=9
    in_valid = 1'b1;
    in_data = 4'h3; tick();
    in_data = 4'h9; tick();
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    frame("fl", 4'b0001, 4'b0000, 4'b0010, 4'b0011);

    // flush on an empty bank is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_ign_valid", out_valid, 1'b0);
    chk("fl_ign_ready", in_ready, 1'b1);
    tick();
    chk("fl_ign_valid2", out_valid, 1'b0);
    chk("fl_ign_ready2", in_ready, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
